spi_master_fifo: RTL and testbench

- Parametrised SPI master engine; successor to the fixed 8-bit, single-SS SPI block.
- Generalises data width, slave-select count and buffering. Adds TX/RX FIFOs, back-to-back continuous transfers, and sticky overflow status.
- Sits between the register/bus front end (FIFO push/pop, config inputs) and the SPI pads (sck, mosi, miso, ss_n).

---
 rtl/spi_master_fifo.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: parametrised SPI master engine with TX/RX FIFOs,
// back-to-back continuous transfers and a sticky RX overflow flag.
// Optional build macro SPI_LOOPBACK_EN adds input loopback_en, which routes
// the internal mosi register into the receive path in place of miso.
module spi_master_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic [2:0]            spr,
    input  logic                  cont,
    input  logic [SS_W-1:0]       ss_sel,
    input  logic                  tx_wr_en,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_full,
    output logic                  tx_empty,
    input  logic                  rx_rd_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  rx_ovf,
    input  logic                  rx_ovf_clr,
    output logic                  spif,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                  loopback_en,
`endif
    output logic [NUM_SS-1:0]     ss_n
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = $clog2(2 * DATA_WIDTH);
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0]         r_tx_cnt, r_rx_cnt;
    logic [BW-1:0]         r_cnt;
    logic [EW-1:0]         r_edge;
    logic [DATA_WIDTH-1:0] r_tx_sh, r_rx_sh;
    logic                  r_mosi, r_sck, r_spif, r_ovf;
    logic [NUM_SS-1:0]     r_ss_n;
    logic                  r_cpol, r_cpha, r_lsbfe, r_cont;
    logic [2:0]            r_spr;

    logic                  w_pop, w_rx_wr, w_done, w_entry, w_abort;
    logic                  w_tx_push, w_rx_push, w_rx_pop;
    logic [8:0]            w_half;
    logic [BW-1:0]         w_term;
    logic                  w_tick, w_xtick, w_odd, w_last, w_sample, w_drive, w_sdi;
    logic [DATA_WIDTH-1:0] w_tx_head, w_tx_shift, w_rx_shift, w_rx_word;
    logic [NUM_SS-1:0]     w_ss_dec;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

`ifdef SPI_LOOPBACK_EN
    assign w_sdi = loopback_en ? r_mosi : miso;
`else
    assign w_sdi = miso;
`endif

    assign tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (r_tx_cnt == '0);
    assign rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (r_rx_cnt == '0);
    assign rx_data  = r_rx_mem[r_rx_rp];
    assign w_tx_head = r_tx_mem[r_tx_rp];

    // Full/empty are judged before any same-cycle pop or push.
    assign w_tx_push = tx_wr_en && !tx_full;
    assign w_rx_push = w_rx_wr && !rx_full;
    assign w_rx_pop  = rx_rd_en && !rx_empty;

    assign w_half   = 9'(9'd1 << (4'(r_spr) + 4'd1));
    assign w_term   = BW'(w_half - 9'd1);
    assign w_tick   = (r_cnt == w_term);
    assign w_xtick  = (r_state == S_XFER) && w_tick && spe;
    assign w_odd    = ~r_edge[0];
    assign w_last   = (r_edge == EW'(2 * DATA_WIDTH - 1));
    assign w_sample = w_xtick && (r_cpha ? !w_odd : w_odd);
    assign w_drive  = w_xtick && (r_cpha ? w_odd : (!w_odd && !w_last));

    assign w_tx_shift = r_lsbfe ? (r_tx_sh >> 1) : (r_tx_sh << 1);
    assign w_rx_shift = r_lsbfe ? {w_sdi, r_rx_sh[DATA_WIDTH-1:1]}
                                : {r_rx_sh[DATA_WIDTH-2:0], w_sdi};
    assign w_rx_word  = w_sample ? w_rx_shift : r_rx_sh;

    assign busy = (r_state != S_IDLE);
    assign spif = r_spif;
    assign sck  = r_sck;
    assign mosi = r_mosi;
    assign ss_n = r_ss_n;
    assign rx_ovf = r_ovf;

    // Active-low one-hot decode of the requested slave.
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < int'(NUM_SS); i++) begin
            if (SS_W'(i) == ss_sel) w_ss_dec[i] = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rx_wr     = 1'b0;
        w_done      = 1'b0;
        w_entry     = 1'b0;
        w_abort     = 1'b0;
        if (r_state != S_IDLE && !spe) begin
            w_abort     = 1'b1;
            w_entry     = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (spe && !tx_empty) begin
                    w_pop       = 1'b1;
                    w_entry     = 1'b1;
                    w_state_nxt = S_LEAD;
                end
                S_LEAD: if (w_tick) begin
                    w_entry     = 1'b1;
                    w_state_nxt = S_XFER;
                end
                S_XFER: if (w_tick && w_last) begin
                    w_rx_wr = 1'b1;
                    w_done  = 1'b1;
                    w_entry = 1'b1;
                    if (r_cont && !tx_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_XFER;
                    end else begin
                        w_state_nxt = S_TRAIL;
                    end
                end
                S_TRAIL: if (w_tick) begin
                    w_entry     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FIFO storage arrays (no reset needed, guarded by counts).
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_word;
    end

    // FIFO pointers, counts and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_pop)     r_tx_rp <= r_tx_rp + AW'(1);
            if (w_tx_push && !w_pop)      r_tx_cnt <= r_tx_cnt + CW'(1);
            else if (!w_tx_push && w_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + CW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
            if (rx_ovf_clr)                r_ovf <= 1'b0;
            else if (w_rx_wr && rx_full)   r_ovf <= 1'b1;
        end
    end

    // Baud/edge counters, shift registers, latched config and pad outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_edge  <= '0;
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_mosi  <= 1'b0;
            r_sck   <= 1'b0;
            r_ss_n  <= '1;
            r_spif  <= 1'b0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsbfe <= 1'b0;
            r_cont  <= 1'b0;
            r_spr   <= '0;
        end else begin
            r_spif <= w_done;
            r_cnt  <= (w_entry || w_tick) ? '0 : r_cnt + BW'(1);
            if (w_entry)      r_edge <= '0;
            else if (w_xtick) r_edge <= r_edge + EW'(1);

            if (w_pop) begin
                r_cpol  <= cpol;
                r_cpha  <= cpha;
                r_lsbfe <= lsbfe;
                r_spr   <= spr;
                r_cont  <= cont;
                r_tx_sh <= w_tx_head;
                if (!cpha) r_mosi <= first_bit(w_tx_head, lsbfe);
            end else if (w_drive) begin
                r_tx_sh <= w_tx_shift;
                r_mosi  <= r_cpha ? first_bit(r_tx_sh, r_lsbfe) : first_bit(w_tx_shift, r_lsbfe);
            end

            if (w_sample) r_rx_sh <= w_rx_shift;

            if (r_state == S_IDLE || w_abort) r_sck <= cpol;
            else if (w_xtick)                 r_sck <= w_odd ? ~r_cpol : r_cpol;

            if (w_state_nxt == S_IDLE)               r_ss_n <= '1;
            else if (r_state == S_IDLE && w_pop)     r_ss_n <= w_ss_dec;
        end
    end
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo with a behavioural SPI slave that
// returns preset response words on miso and captures the word seen on mosi.
module tb_spi_master_fifo;
    logic       clk = 1'b0;
    logic       rst, spe, cpol, cpha, lsbfe, cont, miso;
    logic [2:0] spr;
    logic [1:0] ss_sel;
    logic       tx_wr_en, rx_rd_en, rx_ovf_clr;
    logic [7:0] tx_data, rx_data;
    logic       tx_full, tx_empty, rx_empty, rx_full, rx_ovf, spif, busy, sck, mosi;
    logic [3:0] ss_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_master_fifo dut (
        .clk(clk), .rst(rst), .spe(spe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .spr(spr), .cont(cont), .ss_sel(ss_sel), .tx_wr_en(tx_wr_en), .tx_data(tx_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_rd_en(rx_rd_en), .rx_data(rx_data),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_ovf(rx_ovf), .rx_ovf_clr(rx_ovf_clr),
        .spif(spif), .busy(busy), .sck(sck), .mosi(mosi), .miso(miso),
`ifdef SPI_LOOPBACK_EN
        .loopback_en(1'b0),
`endif
        .ss_n(ss_n)
    );

    // Slave model: response index = number of words completed so far.
    logic       sel_n;
    logic [7:0] s_resp [64];
    logic [7:0] s_cap  [64];
    logic [7:0] s_out, s_in;
    int         s_nc = 0, s_e = 0, s_edges = 0;
    int         m_sel = 0, m_spif = 0;

    assign sel_n = &ss_n;

    function automatic logic pick(input logic [7:0] w, input int k, input logic lsb);
        return lsb ? w[k] : w[7-k];
    endfunction

    always @(negedge sel_n) begin
        s_e = 0;
        s_in = 8'h00;
        s_out = s_resp[s_nc];
        if (!cpha) miso = pick(s_out, 0, lsbfe);
    end

    always @(sck) begin
        if (sel_n === 1'b0) begin
            int k;
            s_e++;
            s_edges++;
            if ((s_e % 2 == 1) != cpha) begin
                k = cpha ? (s_e - 2) / 2 : (s_e - 1) / 2;
                if (lsbfe) s_in[k] = mosi;
                else       s_in[7-k] = mosi;
            end else if (cpha) begin
                miso = pick(s_out, (s_e - 1) / 2, lsbfe);
            end else if (s_e < 16) begin
                miso = pick(s_out, s_e / 2, lsbfe);
            end
            if (s_e == 16) begin
                s_cap[s_nc] = s_in;
                s_nc++;
                s_e = 0;
                s_in = 8'h00;
                s_out = s_resp[s_nc];
                if (!cpha) miso = pick(s_out, 0, lsbfe);
            end
        end
    end

    // Cycle monitors for slave-select duration and spif pulses.
    always @(negedge clk) begin
        if (sel_n === 1'b0) m_sel++;
        if (spif === 1'b1)  m_spif++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_wr_en = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic pop_rx();
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || tx_empty !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_idle: observed timeout expected idle");
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [2:0] spr;
        logic [7:0] resp;
        int         sel_cyc;
    } mode_t;

    initial begin
        mode_t      modes [3];
        logic [7:0] drain [4];
        int cp = 0, b_spif, b_sel, b_edges, n;

        modes[0] = '{cpol: 1'b0, cpha: 1'b1, spr: 3'd0, resp: 8'h5A, sel_cyc: 36};
        modes[1] = '{cpol: 1'b1, cpha: 1'b0, spr: 3'd0, resp: 8'hC3, sel_cyc: 36};
        modes[2] = '{cpol: 1'b1, cpha: 1'b1, spr: 3'd1, resp: 8'h96, sel_cyc: 72};
        drain[0] = 8'h10; drain[1] = 8'h20; drain[2] = 8'h30; drain[3] = 8'h40;

        rst = 1'b1; spe = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; spr = 3'd0;
        cont = 1'b0; ss_sel = 2'd0; tx_wr_en = 1'b0; tx_data = 8'h00; rx_rd_en = 1'b0;
        rx_ovf_clr = 1'b0; miso = 1'b0;
        for (int i = 0; i < 64; i++) s_resp[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ss_n", 32'(ss_n), 32'hF);
        chk("rst_sck", 32'(sck), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_spif", 32'(spif), 32'h0);
        chk("rst_tx_empty", 32'(tx_empty), 32'h1);
        chk("rst_rx_empty", 32'(rx_empty), 32'h1);
        chk("rst_rx_ovf", 32'(rx_ovf), 32'h0);

        // Mode 0, MSB first, 0xA5 out / 0x3C in on slave 2
        s_resp[cp] = 8'h3C;
        ss_sel = 2'd2; spe = 1'b1;
        b_spif = m_spif; b_sel = m_sel; b_edges = s_edges;
        push(8'hA5);
        repeat (2) @(negedge clk);
        chk("m0_ss_n_sel2", 32'(ss_n), 32'hB);
        chk("m0_busy", 32'(busy), 32'h1);
        wait_idle();
        chk("m0_mosi_word", 32'(s_cap[cp]), 32'hA5);
        chk("m0_rx_data", 32'(rx_data), 32'h3C);
        chk("m0_sck_edges", 32'(s_edges - b_edges), 32'd16);
        chk("m0_spif_pulses", 32'(m_spif - b_spif), 32'd1);
        chk("m0_ss_low_cycles", 32'(m_sel - b_sel), 32'd36);
        chk("m0_ss_n_after", 32'(ss_n), 32'hF);
        pop_rx();
        chk("m0_rx_empty", 32'(rx_empty), 32'h1);
        cp++;

        // Modes 1..3, LSB first, 0x81 out
        lsbfe = 1'b1; ss_sel = 2'd0;
        for (int m = 0; m < 3; m++) begin
            cpol = modes[m].cpol; cpha = modes[m].cpha; spr = modes[m].spr;
            s_resp[cp] = modes[m].resp;
            repeat (2) @(negedge clk);
            chk("mode_sck_idle", 32'(sck), 32'(modes[m].cpol));
            b_spif = m_spif; b_sel = m_sel; b_edges = s_edges;
            push(8'h81);
            wait_idle();
            chk("mode_mosi_word", 32'(s_cap[cp]), 32'h81);
            chk("mode_rx_data", 32'(rx_data), 32'(modes[m].resp));
            chk("mode_sck_edges", 32'(s_edges - b_edges), 32'd16);
            chk("mode_spif_pulses", 32'(m_spif - b_spif), 32'd1);
            chk("mode_ss_low_cycles", 32'(m_sel - b_sel), 32'(modes[m].sel_cyc));
            chk("mode_sck_rest", 32'(sck), 32'(modes[m].cpol));
            pop_rx();
            cp++;
        end

        // Continuous three-word burst
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; spr = 3'd0; cont = 1'b1;
        s_resp[cp] = 8'hA1; s_resp[cp+1] = 8'hB2; s_resp[cp+2] = 8'hC3;
        repeat (2) @(negedge clk);
        b_spif = m_spif; b_sel = m_sel; b_edges = s_edges;
        push(8'h11); push(8'h22); push(8'h33);
        wait_idle();
        chk("cont_ss_low_cycles", 32'(m_sel - b_sel), 32'd100);
        chk("cont_spif_pulses", 32'(m_spif - b_spif), 32'd3);
        chk("cont_sck_edges", 32'(s_edges - b_edges), 32'd48);
        chk("cont_mosi_w0", 32'(s_cap[cp]), 32'h11);
        chk("cont_mosi_w2", 32'(s_cap[cp+2]), 32'h33);
        chk("cont_rx_w0", 32'(rx_data), 32'hA1);
        pop_rx();
        chk("cont_rx_w1", 32'(rx_data), 32'hB2);
        pop_rx();
        chk("cont_rx_w2", 32'(rx_data), 32'hC3);
        pop_rx();
        cp += 3;
        cont = 1'b0;

        // RX overflow with no reads, then clear priority
        for (int i = 0; i < 5; i++) s_resp[cp+i] = 8'((i + 1) * 16);
        for (int i = 0; i < 5; i++) push(8'(i + 1));
        wait_idle();
        chk("ovf_rx_full", 32'(rx_full), 32'h1);
        chk("ovf_set", 32'(rx_ovf), 32'h1);
        chk("ovf_mosi_w4", 32'(s_cap[cp+4]), 32'h05);
        cp += 5;
        rx_ovf_clr = 1'b1;
        @(negedge clk);
        rx_ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(rx_ovf), 32'h0);
        s_resp[cp] = 8'h60;
        rx_ovf_clr = 1'b1;
        push(8'h06);
        n = 0;
        while (spif !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_spif_seen", 32'(spif), 32'h1);
        chk("ovf_clr_priority", 32'(rx_ovf), 32'h0);
        rx_ovf_clr = 1'b0;
        wait_idle();
        cp++;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", 32'(rx_data), 32'(drain[i]));
            pop_rx();
        end
        chk("ovf_drain_empty", 32'(rx_empty), 32'h1);

        // Abort mid-word after 5 sck edges
        spe = 1'b0;
        s_resp[cp] = 8'hE7;
        push(8'h77); push(8'h66);
        b_spif = m_spif; b_edges = s_edges;
        spe = 1'b1;
        n = 0;
        while (s_edges - b_edges < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_edges_reached", 32'(s_edges - b_edges), 32'd5);
        chk("abort_sck_high", 32'(sck), 32'h1);
        spe = 1'b0;
        @(negedge clk);
        chk("abort_ss_n", 32'(ss_n), 32'hF);
        chk("abort_sck", 32'(sck), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_no_spif", 32'(m_spif - b_spif), 32'd0);
        chk("abort_tx_kept", 32'(tx_empty), 32'h0);
        chk("abort_rx_empty", 32'(rx_empty), 32'h1);
        spe = 1'b1;
        wait_idle();
        chk("abort_resend_mosi", 32'(s_cap[cp]), 32'h66);
        chk("abort_resend_rx", 32'(rx_data), 32'hE7);
        chk("abort_resend_spif", 32'(m_spif - b_spif), 32'd1);
        pop_rx();
        cp++;

        // TX FIFO boundaries: push on empty, fill, push on full with engine pop
        spe = 1'b0;
        chk("txf_empty_before", 32'(tx_empty), 32'h1);
        push(8'hA0);
        chk("txf_not_empty", 32'(tx_empty), 32'h0);
        push(8'hB0); push(8'hC0); push(8'hD0);
        chk("txf_full", 32'(tx_full), 32'h1);
        tx_wr_en = 1'b1; tx_data = 8'hEE; spe = 1'b1;
        @(negedge clk);
        tx_wr_en = 1'b0;
        chk("txf_push_on_full", 32'(tx_full), 32'h0);
        wait_idle();
        chk("txf_words_sent", 32'(s_nc - cp), 32'd4);
        chk("txf_first", 32'(s_cap[cp]), 32'hA0);
        chk("txf_last", 32'(s_cap[cp+3]), 32'hD0);
        chk("txf_rx_full", 32'(rx_full), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
